vga_scan_ctrl: RTL

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
// vga_scan_ctrl
//
// VGA timing generator and pixel fetch pipeline. A free-running h/v scan
// counter walks each line as sync, back porch, active, front porch, and each
// frame in the same order. Stage 1 turns the count into a pixel-memory read
// (row/col address plus an active-low strobe). The sync, enable, border and
// pulse flags then travel down an RD_LAT-deep delay line so that they leave
// the block on the same clock as the colour that memory returns for that
// pixel.
//
// Ports
//   vga_clk      pixel clock
//   clrn         asynchronous active-low reset
//   scale        upscale select (0 = 1x, 1 = 2x, 2 = 4x, 3 = 1x), sampled
//                only at the first count of a frame
//   border_en    overlay a 1-pixel border of border_color on the active area
//   border_color border pixel, {b, g, r} packing
//   d_in         pixel data from memory, {b, g, r} packing
//   row_addr     pixel-memory row address (held outside the active area)
//   col_addr     pixel-memory column address (held outside the active area)
//   rdn          read strobe, low for exactly the active pixels
//   r, g, b      colour outputs, zero whenever de is low
//   hs, vs       sync outputs, active level set by HS_POL / VS_POL
//   de           display enable, aligned with r/g/b
//   line_start   one-cycle pulse on the output cycle of h = 0
//   frame_start  one-cycle pulse on the output cycle of h = 0, v = 0
//
// Pipeline contract: stage-1 registers are loaded at edge k, memory presents
// d_in before edge k + RD_LAT, and r/g/b/hs/vs/de/pulses for that pixel all
// register at edge k + RD_LAT. H_TOTAL and V_TOTAL must not exceed 1024 and
// RD_LAT must be 1..4.
module vga_scan_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 4,
    parameter int   RD_LAT   = 1
) (
    input  logic            vga_clk,
    input  logic            clrn,
    input  logic [1:0]      scale,
    input  logic            border_en,
    input  logic [3*CW-1:0] border_color,
    input  logic [3*CW-1:0] d_in,
    output logic [9:0]      row_addr,
    output logic [9:0]      col_addr,
    output logic            rdn,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic            line_start,
    output logic            frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LO  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);
    localparam logic       HS_IDLE   = ~HS_POL;
    localparam logic       VS_IDLE   = ~VS_POL;

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [1:0] shift_q;      // latched scale, already folded to a shift amount

    logic       at_origin;
    logic       active;
    logic       on_border;
    logic       hs_now;
    logic       vs_now;
    logic [9:0] x_pos;
    logic [9:0] y_pos;

    // Bit 0 is the stage-1 copy; bit RD_LAT is what leaves the block.
    logic [RD_LAT:0] p_hs;
    logic [RD_LAT:0] p_vs;
    logic [RD_LAT:0] p_de;
    logic [RD_LAT:0] p_bd;    // border_en already folded in
    logic [RD_LAT:0] p_ls;
    logic [RD_LAT:0] p_fs;

    // ---------------------------------------------------------------------
    // Scan counters
    // ---------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    // Scale only changes at the frame origin so a frame never mixes zooms.
    // Code 3 is folded to 1x here so the datapath only ever sees 0..2.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            shift_q <= '0;
        end else if (at_origin) begin
            shift_q <= (scale == 2'd3) ? 2'd0 : scale;
        end
    end

    // ---------------------------------------------------------------------
    // Decode of the current count
    // ---------------------------------------------------------------------
    always_comb begin
        at_origin = (h_count == 10'd0) && (v_count == 10'd0);
        active    = (h_count >= H_ACT_LO) && (h_count <= H_ACT_HI) &&
                    (v_count >= V_ACT_LO) && (v_count <= V_ACT_HI);
        // Only meaningful inside the active area; wraps harmlessly elsewhere.
        x_pos     = h_count - H_ACT_LO;
        y_pos     = v_count - V_ACT_LO;
        on_border = (x_pos == 10'd0) || (x_pos == X_LAST) ||
                    (y_pos == 10'd0) || (y_pos == Y_LAST);
        hs_now    = (h_count < H_SYNC_W) ? HS_POL : HS_IDLE;
        vs_now    = (v_count < V_SYNC_W) ? VS_POL : VS_IDLE;
    end

    // ---------------------------------------------------------------------
    // Stage 1, flag delay line and colour output
    // ---------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            row_addr <= '0;
            col_addr <= '0;
            rdn      <= 1'b1;
            p_hs     <= {(RD_LAT+1){HS_IDLE}};
            p_vs     <= {(RD_LAT+1){VS_IDLE}};
            p_de     <= '0;
            p_bd     <= '0;
            p_ls     <= '0;
            p_fs     <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            rdn <= ~active;
            // Addresses hold through blanking so memory sees no spurious change.
            if (active) begin
                col_addr <= x_pos >> shift_q;
                row_addr <= y_pos >> shift_q;
            end

            p_hs <= {p_hs[RD_LAT-1:0], hs_now};
            p_vs <= {p_vs[RD_LAT-1:0], vs_now};
            p_de <= {p_de[RD_LAT-1:0], active};
            p_bd <= {p_bd[RD_LAT-1:0], active & border_en & on_border};
            p_ls <= {p_ls[RD_LAT-1:0], (h_count == 10'd0)};
            p_fs <= {p_fs[RD_LAT-1:0], at_origin};

            // Colour registers in the same edge as the last delay stage, so
            // decide from the flags one stage earlier.
            if (!p_de[RD_LAT-1]) begin
                {b, g, r} <= '0;
            end else if (p_bd[RD_LAT-1]) begin
                {b, g, r} <= border_color;
            end else begin
                {b, g, r} <= d_in;
            end
        end
    end

    assign hs          = p_hs[RD_LAT];
    assign vs          = p_vs[RD_LAT];
    assign de          = p_de[RD_LAT];
    assign line_start  = p_ls[RD_LAT];
    assign frame_start = p_fs[RD_LAT];

endmodule
